// File: rtl/pio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_arb_pkg
// Description : Shared definitions for the green-LED PIO write arbiter.
//               Holds the requester op encoding, the PIO slave register
//               addresses, the FSM state type and an op-to-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_arb_pkg;

    // Requester operation encoding (2 bits per requester)
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_CLR   = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    // PIO slave register map: data, outset, outclear
    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    // FSM state type and encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    // Maps a requester op onto the PIO register it targets.
    function automatic logic [2:0] op_to_addr(input logic [1:0] op);
        logic [2:0] addr;
        case (op)
            OP_SET:  addr = ADDR_SET;
            OP_CLR:  addr = ADDR_CLR;
            default: addr = ADDR_DATA;
        endcase
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Purely combinational round-robin picker. Grants the lowest
//               requesting index at or after ptr_i, wrapping modulo NUM_REQ.
// Ports       : req_i       - request vector
//               ptr_i       - round-robin start index (must be < NUM_REQ)
//               grant_o     - one-hot grant (all zero when no request)
//               grant_idx_o - binary index of the granted requester
//               any_o       - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               any_o
);

    always_comb begin
        int j;
        j           = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = |req_i;
        // Walk from the farthest offset down to offset 0 so that the
        // candidate closest to ptr_i is the last to overwrite the result.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req_i[j]) begin
                grant_o     = '0;
                grant_o[j]  = 1'b1;
                grant_idx_o = PTR_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pio_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pio_write_arbiter
// Description : Shares the green-LED PIO output register among NUM_REQ
//               requesters. Ops (write/set/clear) are accepted round-robin
//               over valid/ready and each becomes one Avalon-MM write to the
//               PIO slave. A shadow register mirrors the PIO output.
// Ports       : clk, reset        - clock, async active-high reset
//               req_valid/op/data - per-requester operation (packed slices)
//               req_ready         - one-hot accept strobe (IDLE only)
//               pio_*             - Avalon-MM write master to the PIO slave
//               shadow            - PIO output value after the last write
//               busy              - FSM is in WRITE or GAP
// Revision    : 1.0 - initial release
// ============================================================================
module pio_write_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 9,
    parameter int GAP_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [DATA_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [2:0]                  pio_address,
    output logic                        pio_chipselect,
    output logic                        pio_write_n,
    output logic [31:0]                 pio_writedata,
    output logic [DATA_W-1:0]           shadow,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_any;
    logic [1:0]         w_op;
    logic [DATA_W-1:0]  w_data;

    state_t             state_q,   state_d;
    logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [1:0]         cmd_op_q,  cmd_op_d;
    logic [DATA_W-1:0]  cmd_data_q, cmd_data_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic               cs_q,      cs_d;
    logic               wr_n_q,    wr_n_d;
    logic [2:0]         addr_q,    addr_d;
    logic [31:0]        wdata_q,   wdata_d;
    logic [DATA_W-1:0]  shadow_q,  shadow_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .any_o       (w_any)
    );

    // Operand of the currently selected requester
    assign w_op   = req_op[2*int'(w_grant_idx) +: 2];
    assign w_data = req_data[DATA_W*int'(w_grant_idx) +: DATA_W];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cmd_op_d   = cmd_op_q;
        cmd_data_d = cmd_data_q;
        gap_cnt_d  = gap_cnt_q;
        cs_d       = 1'b0;
        wr_n_d     = 1'b1;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        shadow_d   = shadow_q;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    // Pointer advances even for reserved ops so a requester
                    // spamming op 3 cannot starve the others.
                    if (int'(w_grant_idx) == NUM_REQ - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = w_grant_idx + PTR_W'(1);
                    end
                    if (w_op != OP_RSVD) begin
                        cmd_op_d   = w_op;
                        cmd_data_d = w_data;
                        addr_d     = op_to_addr(w_op);
                        wdata_d    = 32'(w_data);
                        cs_d       = 1'b1;
                        wr_n_d     = 1'b0;
                        state_d    = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                // The PIO latches on this cycle; mirror its effect.
                case (cmd_op_q)
                    OP_SET:  shadow_d = shadow_q | cmd_data_q;
                    OP_CLR:  shadow_d = shadow_q & ~cmd_data_q;
                    default: shadow_d = cmd_data_q;
                endcase
                if (GAP_CYCLES > 0) begin
                    gap_cnt_d = 4'(GAP_CYCLES);
                    state_d   = ST_GAP;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_GAP: begin
                // Counter holds the remaining GAP cycles including this one.
                if (gap_cnt_q <= 4'd1) begin
                    gap_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            cmd_op_q   <= OP_WRITE;
            cmd_data_q <= '0;
            gap_cnt_q  <= 4'd0;
            cs_q       <= 1'b0;
            wr_n_q     <= 1'b1;
            addr_q     <= 3'd0;
            wdata_q    <= 32'd0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cmd_op_q   <= cmd_op_d;
            cmd_data_q <= cmd_data_d;
            gap_cnt_q  <= gap_cnt_d;
            cs_q       <= cs_d;
            wr_n_q     <= wr_n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            shadow_q   <= shadow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The ready path is combinational, so it is masked by reset as well:
    // the FSM is already IDLE while reset is held, but nothing may be
    // accepted until reset is released.
    assign req_ready      = (state_q == ST_IDLE && !reset) ? w_grant : '0;
    assign pio_address    = addr_q;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wr_n_q;
    assign pio_writedata  = wdata_q;
    assign shadow         = shadow_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pio_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_write_arbiter
// Description : Self-checking bench for pio_write_arbiter. A cycle-level
//               reference model (grant rotation, accept spacing, pending bus
//               write, shadow arithmetic) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_write_arbiter;

    localparam int N   = 4;
    localparam int DW  = 9;
    localparam int GAP = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [2*N-1:0]    req_op;
    logic [DW*N-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [2:0]        pio_address;
    logic              pio_chipselect;
    logic              pio_write_n;
    logic [31:0]       pio_writedata;
    logic [DW-1:0]     shadow;
    logic              busy;

    pio_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_W     (DW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .shadow         (shadow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Requester-side state
    bit         bv   [N];
    logic [1:0] bop  [N];
    logic [8:0] bdat [N];
    bit         rand_mode = 1'b0;

    // Reference model
    int          cyc = 0;
    int          ptr, next_acc, wr_cyc;
    logic [2:0]  m_addr, p_addr;
    logic [31:0] m_data, p_data;
    logic [1:0]  p_op;
    logic [8:0]  sh;

    // Grant log for ordering checks
    bit log_en = 1'b0;
    int glog[$];
    int gcyc[$];

    task automatic model_reset();
        ptr = 0; next_acc = cyc; wr_cyc = -1;
        m_addr = 3'd0; m_data = 32'd0; sh = 9'd0;
    endtask

    task automatic drive_pins();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = bv[i];
            req_op[2*i +: 2]    = bop[i];
            req_data[DW*i +: DW] = bdat[i];
        end
    endtask

    task automatic random_drive();
        for (int i = 0; i < N; i++) begin
            if (!bv[i]) begin
                if ($urandom_range(0, 99) < 30) begin
                    bv[i]   = 1'b1;
                    bop[i]  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    bdat[i] = 9'($urandom);
                end
            end else if ($urandom_range(0, 99) < 3) begin
                bv[i] = 1'b0;
            end
        end
    endtask

    // Predict and compare all outputs for the current cycle, then advance model.
    task automatic check_step();
        logic [N-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        g = -1;
        if (cyc >= next_acc) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        if (wr_cyc == cyc) begin
            m_addr = p_addr;
            m_data = p_data;
        end
        check("req_ready",  32'(req_ready),      32'(exp_rdy));
        check("chipselect", 32'(pio_chipselect), 32'(wr_cyc == cyc));
        check("write_n",    32'(pio_write_n),    32'(wr_cyc != cyc));
        check("address",    32'(pio_address),    32'(m_addr));
        check("writedata",  pio_writedata,       m_data);
        check("shadow",     32'(shadow),         32'(sh));
        check("busy",       32'(busy),           32'(cyc < next_acc));
        if (wr_cyc == cyc) begin
            case (p_op)
                2'd1:    sh = sh | p_data[8:0];
                2'd2:    sh = sh & ~p_data[8:0];
                default: sh = p_data[8:0];
            endcase
        end
        if (g >= 0) begin
            logic [1:0] op;
            op  = req_op[2*g +: 2];
            ptr = (g + 1) % N;
            if (log_en) begin
                glog.push_back(g);
                gcyc.push_back(cyc);
            end
            if (op != 2'd3) begin
                wr_cyc   = cyc + 1;
                p_op     = op;
                p_addr   = (op == 2'd0) ? 3'd0 : (op == 2'd1) ? 3'd4 : 3'd5;
                p_data   = 32'(req_data[DW*g +: DW]);
                next_acc = cyc + 2 + GAP;
            end else begin
                next_acc = cyc + 1;
            end
        end
        // A requester stops presenting an op once the DUT has taken it.
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) bv[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) random_drive();
        drive_pins();
        @(negedge clk);
        check_step();
        cyc++;
    endtask

    task automatic run_op(input int i, input logic [1:0] op, input logic [8:0] data);
        bv[i] = 1'b1; bop[i] = op; bdat[i] = data;
        for (int k = 0; k < 20 && bv[i]; k++) tick();
        if (bv[i]) check("accept_timeout", 32'd0, 32'd1);
        repeat (2 + GAP) tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            bv[i] = 1'b0; bop[i] = 2'd0; bdat[i] = 9'd0;
        end
        reset = 1'b1;
        drive_pins();
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_chipselect", 32'(pio_chipselect), 32'd0);
        check("rst_write_n",    32'(pio_write_n),    32'd1);
        check("rst_shadow",     32'(shadow),         32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        reset = 1'b0;

        // Round-robin with everyone continuously valid
        log_en = 1'b1;
        for (int k = 0; k < 40 && glog.size() < 5; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!bv[i]) begin
                    bv[i] = 1'b1; bop[i] = 2'd0; bdat[i] = 9'($urandom);
                end
            end
            tick();
        end
        log_en = 1'b0;
        if (glog.size() >= 5) begin
            int exp_order [5] = '{0, 1, 2, 3, 0};
            for (int k = 0; k < 5; k++) check("rr_order", 32'(glog[k]), 32'(exp_order[k]));
            for (int k = 1; k < 5; k++) check("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'(2 + GAP));
        end else begin
            check("rr_grants", 32'(glog.size()), 32'd5);
        end
        for (int i = 0; i < N; i++) bv[i] = 1'b0;
        repeat (4) tick();

        // Single write, then set and clear on a known pattern
        run_op(1, 2'd0, 9'h1A5);
        check("single_shadow", 32'(shadow), 32'h1A5);
        run_op(0, 2'd0, 9'h0F0);
        run_op(0, 2'd1, 9'h003);
        check("set_shadow", 32'(shadow), 32'h0F3);
        run_op(2, 2'd2, 9'h030);
        check("clr_shadow", 32'(shadow), 32'h0C3);

        // Reserved op: acked, no write, pointer still rotates
        glog.delete(); gcyc.delete();
        log_en = 1'b1;
        bv[3] = 1'b1; bop[3] = 2'd3; bdat[3] = 9'h1FF;
        tick();
        bv[0] = 1'b1; bop[0] = 2'd0; bdat[0] = 9'h044;
        bv[1] = 1'b1; bop[1] = 2'd0; bdat[1] = 9'h022;
        tick();
        check("rsvd_shadow", 32'(shadow), 32'h0C3);
        repeat (10) tick();
        log_en = 1'b0;
        if (glog.size() >= 2) begin
            check("rsvd_grant", 32'(glog[0]), 32'd3);
            check("after_rsvd_grant", 32'(glog[1]), 32'd0);
        end else begin
            check("rsvd_grants", 32'(glog.size()), 32'd2);
        end

        // Withdrawal while another op is being serviced
        run_op(0, 2'd0, 9'h111);
        bv[0] = 1'b1; bop[0] = 2'd0; bdat[0] = 9'h0AA;
        tick();
        bv[2] = 1'b1; bop[2] = 2'd2; bdat[2] = 9'h0FF;
        tick();
        bv[2] = 1'b0;
        repeat (5) tick();
        check("withdraw_shadow", 32'(shadow), 32'h0AA);
        check("withdraw_busy",   32'(busy),   32'd0);

        // Randomized traffic
        rand_mode = 1'b1;
        repeat (1500) tick();
        rand_mode = 1'b0;
        for (int i = 0; i < N; i++) bv[i] = 1'b0;
        repeat (6) tick();

        // Reset asserted in the middle of a WRITE cycle
        bv[1] = 1'b1; bop[1] = 2'd1; bdat[1] = 9'h155;
        tick();
        @(posedge clk);
        #2;
        check("pre_rst_chipselect", 32'(pio_chipselect), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_chipselect", 32'(pio_chipselect), 32'd0);
        check("midrst_write_n",    32'(pio_write_n),    32'd1);
        check("midrst_address",    32'(pio_address),    32'd0);
        check("midrst_writedata",  pio_writedata,       32'd0);
        check("midrst_shadow",     32'(shadow),         32'd0);
        check("midrst_ready",      32'(req_ready),      32'd0);
        check("midrst_busy",       32'(busy),           32'd0);
        for (int i = 0; i < N; i++) bv[i] = 1'b0;
        drive_pins();
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        model_reset();
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pio_write_arbiter.md
Name: pio_write_arbiter

Overview:
Shares the 9-bit green-LED PIO output register among NUM_REQ independent requesters, such as the NIOS-side software bridge, the PFC fault monitor and the status heartbeat. Each requester posts write, set-bits or clear-bits operations over a valid/ready handshake. The block arbitrates them round-robin and issues one Avalon-MM write per operation on the PIO slave port (address 0, 4 or 5). It keeps a shadow copy of the PIO output so requesters can read the current LED state without a bus read.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 9, PIO output width
GAP_CYCLES, 1, idle cycles inserted after each bus write before the next grant (0..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operation pending
req_op  in  2*NUM_REQ  per-requester op, slice i = [2i+1:2i]; 0=write, 1=set, 2=clear, 3=reserved
req_data  in  DATA_W*NUM_REQ  per-requester operand, slice i = [DATA_W*(i+1)-1:DATA_W*i]
req_ready  out  NUM_REQ  one-hot accept strobe; op i is consumed in a cycle where req_valid[i] && req_ready[i]
pio_address  out  3  to PIO slave address
pio_chipselect  out  1  to PIO slave chipselect
pio_write_n  out  1  to PIO slave write_n, active low
pio_writedata  out  32  to PIO slave writedata; upper 32-DATA_W bits are 0
shadow  out  DATA_W  mirror of PIO out_port after the last issued write
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, any time, including mid-write): FSM=IDLE, rr_ptr=0, req_ready=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, shadow=0. This matches the PIO's own reset value of 0.
- FSM states: IDLE, WRITE, GAP.
- IDLE: if any req_valid bit is set, grant the lowest index at or after rr_ptr, wrapping modulo NUM_REQ. req_ready[g] is combinational in IDLE only. The same cycle latches op/data into the command register, sets rr_ptr=(g+1) mod NUM_REQ and goes to WRITE. If no req_valid bit is set, stay in IDLE.
- Reserved op 3: the requester is still acked (req_ready=1) and rr_ptr still advances. No bus write occurs, shadow is unchanged, and the FSM stays in IDLE.
- WRITE: lasts exactly 1 cycle. pio_chipselect=1, pio_write_n=0, pio_writedata={0,data}, pio_address = 0 for write, 4 for set, 5 for clear.
  - shadow update at the end of WRITE: write gives shadow=data; set gives shadow|=data; clear gives shadow&=~data.
  - Next state: GAP if GAP_CYCLES>0, else IDLE.
- Outside WRITE, bus outputs are registered idle: chipselect=0, write_n=1. Address and writedata hold their last value.
- GAP: a counter loads GAP_CYCLES on entry and decrements to 0, then the FSM returns to IDLE.
- Latency: accept at cycle N, bus write at cycle N+1, shadow valid at N+2, earliest next accept at N+2+GAP_CYCLES.
- A requester may hold req_valid without a grant indefinitely. req_op and req_data must stay stable while req_valid is high and unacknowledged; this is the requester's obligation and is not checked.
- A requester deasserting req_valid before its grant is legal; nothing is issued for it.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Set/clear of bits already in the target state still issue the bus write; there is no filtering.

Decomposition:
- Shared package pio_arb_pkg holds:
  - op encoding constants OP_WRITE=0, OP_SET=1, OP_CLR=2;
  - PIO address constants ADDR_DATA=0, ADDR_SET=4, ADDR_CLR=5;
  - the FSM state typedef.
- One sub-module: rr_arbiter (NUM_REQ requests plus rr_ptr in, one-hot grant and grant index out, purely combinational). Everything else stays in pio_write_arbiter.

Test Plan:
- Reset: assert reset mid-WRITE -> bus outputs go idle immediately, shadow=0, req_ready=0; after release with no requests, busy stays 0.
- Single requester: req1 write 0x1A5 -> pio_address=0, writedata=0x000001A5 for exactly 1 cycle, shadow=0x1A5 two cycles after accept.
- Set then clear: from shadow=0x0F0, req0 set 0x003 -> address 4, shadow=0x0F3; then req2 clear 0x030 -> address 5, shadow=0x0C3.
- Round-robin: all 4 requesters valid continuously with GAP_CYCLES=1 -> grant order 0,1,2,3,0; accepts spaced exactly 3 cycles apart.
- Reserved op: req3 op=3 -> req_ready[3] pulses, no chipselect, shadow unchanged, next grant goes to req0.
- Withdrawal: req2 valid for 1 cycle while req0 is being serviced, then dropped -> no write is issued for req2; busy returns to 0 after the GAP state.
